// File: rtl/led_mux_drv_pkg.sv
// rtl/led_mux_drv_pkg.sv - shared constants, types and width helpers for the LED matrix driver
//
// Purpose: holds the default geometry and timing of the 3x6 LED matrix scan,
// the fixed 16-step on-phase split, the slot phase enum, and the constant
// functions the driver uses to size its counters from its parameters.
// Ports: none (package).
package led_mux_drv_pkg;

  // Default scan geometry/timing (1 us tick at 135 MHz).
  localparam int LP_DEF_PDIV_N  = 135;
  localparam int LP_DEF_ROW_N   = 3;
  localparam int LP_DEF_COL_N   = 6;
  localparam int LP_DEF_LED_N   = 18;
  localparam int LP_DEF_BLANK_N = 40;
  localparam int LP_DEF_STEP_N  = 60;

  // The on-phase is always split into 16 sub-steps, whether or not PWM is built.
  localparam int LP_PWM_STEPS   = 16;
  localparam int LP_BRIGHT_W    = 4;
  localparam int LP_STEP_IDX_W  = 4;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  // Bits needed to hold 0..n-1; never less than 1 so a 1-state counter
  // still has a legal vector width.
  function automatic int log2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Ticks per row slot: blanking followed by the 16-step on-phase.
  function automatic int slot_len(input int blank_n, input int step_n);
    return blank_n + LP_PWM_STEPS * step_n;
  endfunction

  localparam int LP_DEF_SLOT_N = slot_len(LP_DEF_BLANK_N, LP_DEF_STEP_N);
  localparam int LP_DEF_PDIV_W = log2(LP_DEF_PDIV_N);
  localparam int LP_DEF_SLOT_W = log2(LP_DEF_SLOT_N);
  localparam int LP_DEF_ROW_W  = log2(LP_DEF_ROW_N);

endpackage

// File: rtl/led_mux_drv_pwm_gate.sv
// rtl/led_mux_drv_pwm_gate.sv - on-phase sub-step counter and optional brightness gate
//
// Purpose: tracks the sub-step index s (0..15) within the on-phase of a row
// slot with a tick/step counter pair (no divider). With LED_MUX_PWM_EN
// defined, it also holds the per-frame brightness snapshot and opens the
// gate while s <= bright snapshot; otherwise the gate is tied to 1.
// Ports:
//   clk       in  1  clock, rising edge
//   rst_n     in  1  asynchronous active-low reset
//   tick      in  1  scan tick (one CK wide)
//   phase_on  in  1  current slot count is in the on-phase
//   slot_wrap in  1  current slot count is the last of the slot
//   snap_en   in  1  frame snapshot strobe (qualified with tick by the caller)
//   bright    in  4  brightness request 0..15
//   gate      out 1  column enable for the current sub-step
module led_pwm_gate
  import led_mux_drv_pkg::*;
#(
  parameter int C_STEP_N = LP_DEF_STEP_N
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   phase_on,
  input  logic                   slot_wrap,
  input  logic                   snap_en,
  input  logic [LP_BRIGHT_W-1:0] bright,
  output logic                   gate
);

  localparam int               LP_TW        = log2(C_STEP_N);
  localparam logic [LP_TW-1:0] LP_TICK_LAST = LP_TW'(C_STEP_N - 1);

  logic [LP_TW-1:0]         tick_cnt;
  logic [LP_STEP_IDX_W-1:0] step;

  // The slot wrap clears the pair before the step index could pass 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      step     <= '0;
    end else if (tick) begin
      if (slot_wrap) begin
        tick_cnt <= '0;
        step     <= '0;
      end else if (phase_on) begin
        if (tick_cnt == LP_TICK_LAST) begin
          tick_cnt <= '0;
          step     <= step + 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

`ifdef LED_MUX_PWM_EN
  logic [LP_BRIGHT_W-1:0] bright_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= '0;
    end else if (snap_en) begin
      bright_q <= bright;
    end
  end

  assign gate = (step <= bright_q);
`else
  // Brightness is not built; the step counter keeps slot timing identical.
  logic unused_bright;
  assign unused_bright = ^{bright, step, snap_en};
  assign gate          = 1'b1;
`endif

endmodule

// File: rtl/led_mux_drv.sv
// rtl/led_mux_drv.sv - time-multiplexed LED matrix driver with anti-ghosting blanking
//
// Purpose: scans a C_ROW_N x C_COL_N LED matrix from the LEDs_ON_i request
// vector. Each row slot opens with C_BLANK_N ticks fully off, then a
// 16-sub-step on-phase. The request (and brightness) is snapshotted once
// per frame so the image never tears mid-scan. Optional 16-level PWM is
// built when the LED_MUX_PWM_EN macro is defined.
// Ports:
//   CK_i      in  1        clock, rising edge
//   XARST_i   in  1        asynchronous active-low reset
//   LEDs_ON_i in  C_LED_N  LED request, bit i -> row i/C_COL_N, col i%C_COL_N
//   BRIGHT_i  in  4        brightness 0..15 (PWM build only)
//   ROWs_o    out C_ROW_N  row enables, active high, at most one set
//   XCOLs_o   out C_COL_N  column sinks, active low
//   FRAME_o   out 1        one-CK pulse marking the frame snapshot
module led_mux_drv
  import led_mux_drv_pkg::*;
#(
  parameter int C_PDIV_N  = LP_DEF_PDIV_N,
  parameter int C_ROW_N   = LP_DEF_ROW_N,
  parameter int C_COL_N   = LP_DEF_COL_N,
  parameter int C_LED_N   = LP_DEF_LED_N,
  parameter int C_BLANK_N = LP_DEF_BLANK_N,
  parameter int C_STEP_N  = LP_DEF_STEP_N
)
(
  input  logic                   CK_i,
  input  logic                   XARST_i,
  input  logic [C_LED_N-1:0]     LEDs_ON_i,
  input  logic [LP_BRIGHT_W-1:0] BRIGHT_i,
  output logic [C_ROW_N-1:0]     ROWs_o,
  output logic [C_COL_N-1:0]     XCOLs_o,
  output logic                   FRAME_o
);

  localparam int LP_SLOT_N = slot_len(C_BLANK_N, C_STEP_N);
  localparam int LP_MAT_N  = C_ROW_N * C_COL_N;
  localparam int LP_PW     = log2(C_PDIV_N);
  localparam int LP_SW     = log2(LP_SLOT_N);
  localparam int LP_RW     = log2(C_ROW_N);

  localparam logic [LP_PW-1:0] LP_PDIV_LAST = LP_PW'(C_PDIV_N - 1);
  localparam logic [LP_SW-1:0] LP_SLOT_LAST = LP_SW'(LP_SLOT_N - 1);
  localparam logic [LP_SW-1:0] LP_BLANK     = LP_SW'(C_BLANK_N);
  localparam logic [LP_RW-1:0] LP_ROW_LAST  = LP_RW'(C_ROW_N - 1);

  logic [LP_PW-1:0]    pdiv_q;
  logic [LP_SW-1:0]    slot_q;
  logic [LP_RW-1:0]    row_q;
  logic [LP_MAT_N-1:0] snap_q;
  logic                ee;
  logic                slot_wrap;
  logic                frame_start;
  logic                gate;
  phase_e              phase;
  logic [C_ROW_N-1:0]  rows_d;
  logic [C_COL_N-1:0]  xcols_d;

  assign ee          = (pdiv_q == LP_PDIV_LAST);
  assign slot_wrap   = (slot_q == LP_SLOT_LAST);
  assign frame_start = ee && (row_q == '0) && (slot_q == '0);
  assign phase       = (slot_q >= LP_BLANK) ? PH_ON : PH_BLANK;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      pdiv_q <= '0;
    end else if (ee) begin
      pdiv_q <= '0;
    end else begin
      pdiv_q <= pdiv_q + 1'b1;
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      slot_q <= '0;
      row_q  <= '0;
    end else if (ee) begin
      if (slot_wrap) begin
        slot_q <= '0;
        row_q  <= (row_q == LP_ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        slot_q <= slot_q + 1'b1;
      end
    end
  end

  // Zero-extending into the full matrix keeps positions >= C_LED_N dark.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      snap_q <= '0;
    end else if (frame_start) begin
      snap_q <= LP_MAT_N'(LEDs_ON_i);
    end
  end

  led_pwm_gate #(
    .C_STEP_N (C_STEP_N)
  ) u_pwm_gate (
    .clk       (CK_i),
    .rst_n     (XARST_i),
    .tick      (ee),
    .phase_on  (phase == PH_ON),
    .slot_wrap (slot_wrap),
    .snap_en   (frame_start),
    .bright    (BRIGHT_i),
    .gate      (gate)
  );

  // Outputs are decoded from the counters and registered, so they trail the
  // tick that moves phase/row/step by one CK. The row can only change at a
  // slot wrap, which always lands in a blank phase.
  always_comb begin
    rows_d  = '0;
    xcols_d = '1;
    if (phase == PH_ON) begin
      for (int r = 0; r < C_ROW_N; r++) begin
        if (row_q == LP_RW'(r)) begin
          rows_d[r] = 1'b1;
          for (int c = 0; c < C_COL_N; c++) begin
            if (gate && snap_q[r * C_COL_N + c]) begin
              xcols_d[c] = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      ROWs_o  <= '0;
      XCOLs_o <= '1;
      FRAME_o <= 1'b0;
    end else begin
      ROWs_o  <= rows_d;
      XCOLs_o <= xcols_d;
      FRAME_o <= frame_start;
    end
  end

endmodule
